// File: rtl/gen_dequeue_mp_pkg.sv
// Shared types and elaboration helpers for the multi-pumped dequeue scheduler.
// Phase values are carried in phase_t, sized for the largest supported pump factor.
package gen_dequeue_pkg;

    localparam int PUMP_MAX    = 8;
    localparam int PHASE_MAX_W = $clog2(PUMP_MAX);

    typedef logic [PHASE_MAX_W-1:0] phase_t;

    // Width of the externally visible phase; a 2x pump still needs one bit.
    function automatic int phase_w(input int pump);
        int w;
        w = $clog2(pump);
        if (w < 1) begin
            return 1;
        end else begin
            return w;
        end
    endfunction

    // Phase 0 is reserved for capture, so slots live in 1..pump-1.
    function automatic int slot_of(input int i, input int pump, input int stagger);
        if (stagger == 0) begin
            return pump - 1;
        end else begin
            return 1 + (i % (pump - 1));
        end
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            return value;
        end else begin
            return value + 8'd1;
        end
    endfunction

endpackage

// File: rtl/gen_dequeue_mp_if.sv
// Bundle between base-rate consumers and the multi-pumped queue read ports.
// Optional slip statistics appear when GEN_DEQUEUE_MP_STATS_EN is defined.
interface gen_dequeue_mp_if #(
    parameter int N       = 4,
    parameter int PHASE_W = 1
);

    logic               sync_in;
    logic [N-1:0]       dequeue_in;
    logic [N-1:0]       empty_in;
    logic [N-1:0]       dequeue_out;
    logic [PHASE_W-1:0] phase_out;
    logic               locked_out;
    logic               slip_out;
`ifdef GEN_DEQUEUE_MP_STATS_EN
    logic [7:0]         slip_count_out;
`endif

    modport master (
        output sync_in,
        output dequeue_in,
        output empty_in,
        input  dequeue_out,
        input  phase_out,
        input  locked_out,
        input  slip_out
`ifdef GEN_DEQUEUE_MP_STATS_EN
        , input slip_count_out
`endif
    );

    modport slave (
        input  sync_in,
        input  dequeue_in,
        input  empty_in,
        output dequeue_out,
        output phase_out,
        output locked_out,
        output slip_out
`ifdef GEN_DEQUEUE_MP_STATS_EN
        , output slip_count_out
`endif
    );

endinterface

// File: rtl/gen_dequeue_mp_chk.sv
// Protocol checker for gen_dequeue_mp: issue gating, phase range, lock and slip rules.
module gen_dequeue_mp_chk #(
    parameter int N       = 4,
    parameter int PUMP    = 2,
    parameter int PHASE_W = 1
) (
    input logic               clock,
    input logic               reset_n,
    input logic               sync_in,
    input logic [N-1:0]       dequeue_out,
    input logic [PHASE_W-1:0] phase_out,
    input logic               locked_out,
    input logic               slip_out
);

    localparam logic [PHASE_W-1:0] LAST_PH = PHASE_W'(PUMP - 1);

    a_no_issue_unlocked : assert property (@(posedge clock) disable iff (!reset_n)
        !locked_out |-> ~|dequeue_out);

    a_no_issue_on_sync : assert property (@(posedge clock) disable iff (!reset_n)
        sync_in |-> ~|dequeue_out);

    a_no_issue_phase0 : assert property (@(posedge clock) disable iff (!reset_n)
        (phase_out == {PHASE_W{1'b0}}) |-> ~|dequeue_out);

    a_slip_needs_sync : assert property (@(posedge clock) disable iff (!reset_n)
        slip_out |-> sync_in);

    a_phase_range : assert property (@(posedge clock) disable iff (!reset_n)
        phase_out <= LAST_PH);

    a_lock_sticky : assert property (@(posedge clock) disable iff (!reset_n)
        locked_out |=> locked_out);

endmodule

// File: rtl/gen_dequeue_mp_phase.sv
// Base-cycle phase tracker: phase counter, lock, slip detection, capture strobe.
// With GEN_DEQUEUE_MP_STATS_EN defined it also keeps a saturating slip count.
module gen_dequeue_phase
    import gen_dequeue_pkg::*;
#(
    parameter int PUMP = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       sync_in,
    output phase_t     ph_r,
    output logic       locked_r,
    output logic       slip_s,
    output logic       capture_s
`ifdef GEN_DEQUEUE_MP_STATS_EN
    , output logic [7:0] slip_count_r
`endif
);

    localparam phase_t LAST_PH = phase_t'(PUMP - 1);

    logic ph_zero_s;

    assign ph_zero_s = (ph_r == 3'd0);

    // A sync pulse marks phase 0 now, so the register jumps straight to phase 1.
    assign slip_s    = sync_in & locked_r & ~ph_zero_s;
    assign capture_s = sync_in | (locked_r & ph_zero_s);

    // Phase counter: sync realigns, otherwise count and wrap after PUMP-1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ph_r <= 3'd0;
        end else if (sync_in) begin
            ph_r <= 3'd1;
        end else if (ph_r == LAST_PH) begin
            ph_r <= 3'd0;
        end else begin
            ph_r <= ph_r + 3'd1;
        end
    end

    // Lock is sticky: only a reset forgets the alignment.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            locked_r <= 1'b0;
        end else if (sync_in) begin
            locked_r <= 1'b1;
        end else begin
            locked_r <= locked_r;
        end
    end

`ifdef GEN_DEQUEUE_MP_STATS_EN
    // Saturating slip counter; it holds once it reaches its ceiling.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slip_count_r <= 8'd0;
        end else if (slip_s) begin
            slip_count_r <= sat_inc8(slip_count_r);
        end else begin
            slip_count_r <= slip_count_r;
        end
    end
`endif

endmodule

// File: rtl/gen_dequeue_mp.sv
// Multi-pumped dequeue scheduler: captures base-rate requests in phase 0 and replays
// each once in its channel's phase slot. GEN_DEQUEUE_MP_STATS_EN adds slip_count_out.
module gen_dequeue_mp
    import gen_dequeue_pkg::*;
#(
    parameter int N       = 4,
    parameter int PUMP    = 2,
    parameter int STAGGER = 0
) (
    input logic             clock,
    input logic             reset_n,
    gen_dequeue_mp_if.slave bus
);

    localparam int PHASE_W = phase_w(PUMP);

    phase_t       ph_r;
    logic         locked_r;
    logic         slip_s;
    logic         capture_s;
    logic [N-1:0] pending_r;
    logic [N-1:0] pending_next_s;
    logic [N-1:0] slot_hit_s;
`ifdef GEN_DEQUEUE_MP_STATS_EN
    logic [7:0]   slip_count_r;
`endif

    gen_dequeue_phase #(
        .PUMP (PUMP)
    ) u_phase (
        .clock        (clock),
        .reset_n      (reset_n),
        .sync_in      (bus.sync_in),
        .ph_r         (ph_r),
        .locked_r     (locked_r),
        .slip_s       (slip_s),
        .capture_s    (capture_s)
`ifdef GEN_DEQUEUE_MP_STATS_EN
        , .slip_count_r (slip_count_r)
`endif
    );

    // Per-channel slot decode, fixed at elaboration.
    for (genvar i = 0; i < N; i++) begin : g_slot
        localparam phase_t SLOT = phase_t'(slot_of(i, PUMP, STAGGER));
        assign slot_hit_s[i] = (ph_r == SLOT);
    end

    // A capture overwrites everything pending, which is how a slip drops old requests.
    always_comb begin
        pending_next_s = pending_r;
        if (capture_s) begin
            pending_next_s = bus.dequeue_in & ~bus.empty_in;
        end else begin
            pending_next_s = pending_r & ~slot_hit_s;
        end
    end

    // Pending request register, one bit per channel.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_r <= {N{1'b0}};
        end else begin
            pending_r <= pending_next_s;
        end
    end

    assign bus.dequeue_out = pending_r & slot_hit_s & {N{locked_r & ~bus.sync_in}};
    assign bus.phase_out   = bus.sync_in ? {PHASE_W{1'b0}} : ph_r[PHASE_W-1:0];
    assign bus.locked_out  = locked_r | bus.sync_in;
    assign bus.slip_out    = slip_s;
`ifdef GEN_DEQUEUE_MP_STATS_EN
    assign bus.slip_count_out = slip_count_r;
`endif

    gen_dequeue_mp_chk #(
        .N       (N),
        .PUMP    (PUMP),
        .PHASE_W (PHASE_W)
    ) u_chk (
        .clock       (clock),
        .reset_n     (reset_n),
        .sync_in     (bus.sync_in),
        .dequeue_out (bus.dequeue_out),
        .phase_out   (bus.phase_out),
        .locked_out  (bus.locked_out),
        .slip_out    (bus.slip_out)
    );

endmodule
